// File: rtl/rgb_to_hsv_pkg.sv
// Shared types and helpers for the RGB-to-HSV stream converter.
// Holds parameter defaults, the sector enum, the pixel bundle and the LUT generator.
package rgb_to_hsv_pkg;

    localparam int CW_DEF      = 8;
    localparam int RB_DEF      = 16;
    localparam int HUE_MAX_DEF = 180;
    localparam int CW_MAX      = 10;
    localparam int PIX_W       = 3 * CW_MAX;

    typedef enum logic [1:0] {
        MOD0 = 2'd0,
        MOD2 = 2'd1,
        MOD4 = 2'd2,
        MOD6 = 2'd3
    } hsv_sector_t;

    // data is sized for the widest channel; narrower builds zero-extend
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sop;
        logic             eop;
    } hsv_pixel_t;

    function automatic int unsigned recip_f(int unsigned rb, int unsigned d);
        if (d == 0) return 0;
        return (32'd1 << rb) / d;
    endfunction

    function automatic logic [2:0] sec_mod(hsv_sector_t s);
        logic [2:0] m;
        m = 3'd0;
        unique case (s)
            MOD0: m = 3'd0;
            MOD2: m = 3'd2;
            MOD4: m = 3'd4;
            MOD6: m = 3'd6;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rgb_to_hsv_stream_lut.sv
// Dual-read reciprocal ROM, entry d = floor(2^RB/d), entry 0 = 0; registered outputs.
// Ports: clk, reset (active-low), en (read enable), addr_a/addr_b -> data_a/data_b.
module hsv_recip_lut
    import rgb_to_hsv_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int RB = RB_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [CW-1:0] addr_a,
    input  logic [CW-1:0] addr_b,
    output logic [RB:0]   data_a,
    output logic [RB:0]   data_b
);

    localparam int N  = 1 << CW;
    localparam int EW = RB + 1;

    logic [RB:0] rom [N];

    for (genvar i = 0; i < N; i++) begin : g_rom
        assign rom[i] = EW'(recip_f(RB, i));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/rgb_to_hsv_stream.sv
// Four-stage pipelined RGB-to-HSV converter with valid/ready and sop/eop sideband.
// Ports: clk, reset (async active-low), in_valid/in_ready/in_rgb/in_sop/in_eop,
// out_valid/out_ready/out_hsv/out_sop/out_eop. Macro RGB2HSV_SKID_EN adds an
// output skid buffer and a registered in_ready.
module rgb_to_hsv_stream
    import rgb_to_hsv_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int RB      = RB_DEF,
    parameter int HUE_MAX = HUE_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*CW-1:0] in_rgb,
    input  logic            in_sop,
    input  logic            in_eop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*CW-1:0] out_hsv,
    output logic            out_sop,
    output logic            out_eop
);

    localparam int K    = HUE_MAX / 6;
    localparam int MAXC = (1 << CW) - 1;
    localparam int HALF = 1 << (RB - 1);
    localparam int PW   = CW + RB + 1;
    localparam int RW   = PW + 3;
    localparam int HW   = RW + CW;
    localparam int HFW  = HW - RB;
    localparam int SW   = PW + CW + 1;
    localparam int SFW  = SW - RB;
    localparam logic [HFW-1:0] HMAX_L = HFW'(HUE_MAX);
    localparam logic [SFW-1:0] MAXC_L = SFW'(MAXC);

    logic [1:0] rst_sync;
    logic       reset_int;
    logic       en;

    // assert immediately, release two clocks later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign reset_int = rst_sync[1];

    // S1: max/min/sector/base
    logic [CW-1:0] r, g, b;
    logic [CW-1:0] c_max, c_min, b_mag;
    logic          b_neg, r_max, g_max;
    hsv_sector_t   sec;

    assign {r, g, b} = in_rgb;
    assign r_max = (r >= g) && (r >= b);
    assign g_max = !r_max && (g >= b);

    always_comb begin
        c_max = r;
        c_min = r;
        sec   = MOD0;
        b_neg = 1'b0;
        b_mag = '0;
        unique case (1'b1)
            r_max: begin
                c_max = r;
                c_min = (g < b) ? g : b;
                sec   = (g >= b) ? MOD0 : MOD6;
                b_neg = (g < b);
                b_mag = (g >= b) ? g - b : b - g;
            end
            g_max: begin
                c_max = g;
                c_min = (r < b) ? r : b;
                sec   = MOD2;
                b_neg = (b < r);
                b_mag = (b < r) ? r - b : b - r;
            end
            default: begin
                c_max = b;
                c_min = (r < g) ? r : g;
                sec   = MOD4;
                b_neg = (r < g);
                b_mag = (r < g) ? g - r : r - g;
            end
        endcase
    end

    logic          s1_v, s1_sop, s1_eop, s1_neg;
    logic [CW-1:0] s1_cmax, s1_delta, s1_mag;
    hsv_sector_t   s1_sec;

    logic          s2_v, s2_sop, s2_eop, s2_neg;
    logic [CW-1:0] s2_cmax, s2_delta, s2_mag;
    hsv_sector_t   s2_sec;
    logic [RB:0]   rc_delta, rc_cmax;

    logic          s3_v, s3_sop, s3_eop, s3_neg, s3_dz;
    logic [CW-1:0] s3_cmax;
    logic [PW-1:0] s3_hp, s3_sp;
    hsv_sector_t   s3_sec;

    always_ff @(posedge clk or negedge reset_int) begin
        if (!reset_int) begin
            s1_v <= 1'b0; s1_sop <= 1'b0; s1_eop <= 1'b0; s1_neg <= 1'b0;
            s1_cmax <= '0; s1_delta <= '0; s1_mag <= '0; s1_sec <= MOD0;
            s2_v <= 1'b0; s2_sop <= 1'b0; s2_eop <= 1'b0; s2_neg <= 1'b0;
            s2_cmax <= '0; s2_delta <= '0; s2_mag <= '0; s2_sec <= MOD0;
            s3_v <= 1'b0; s3_sop <= 1'b0; s3_eop <= 1'b0; s3_neg <= 1'b0;
            s3_dz <= 1'b0; s3_cmax <= '0; s3_hp <= '0; s3_sp <= '0;
            s3_sec <= MOD0;
        end else if (en) begin
            s1_v     <= in_valid & in_ready;
            s1_sop   <= in_sop;
            s1_eop   <= in_eop;
            s1_neg   <= b_neg;
            s1_cmax  <= c_max;
            s1_delta <= c_max - c_min;
            s1_mag   <= b_mag;
            s1_sec   <= sec;
            s2_v     <= s1_v;
            s2_sop   <= s1_sop;
            s2_eop   <= s1_eop;
            s2_neg   <= s1_neg;
            s2_cmax  <= s1_cmax;
            s2_delta <= s1_delta;
            s2_mag   <= s1_mag;
            s2_sec   <= s1_sec;
            s3_v     <= s2_v;
            s3_sop   <= s2_sop;
            s3_eop   <= s2_eop;
            s3_neg   <= s2_neg;
            s3_dz    <= (s2_delta == '0);
            s3_cmax  <= s2_cmax;
            s3_hp    <= PW'(s2_mag) * PW'(rc_delta);
            s3_sp    <= PW'(s2_delta) * PW'(rc_cmax);
            s3_sec   <= s2_sec;
        end
    end

    hsv_recip_lut #(.CW(CW), .RB(RB)) u_lut (
        .clk    (clk),
        .reset  (reset_int),
        .en     (en),
        .addr_a (s1_delta),
        .addr_b (s1_cmax),
        .data_a (rc_delta),
        .data_b (rc_cmax)
    );

    // S4: merge sign, scale, round, wrap/clamp
    logic [RW-1:0]  mod_term, raw;
    logic [HW-1:0]  h_prod;
    logic [SW-1:0]  s_prod;
    logic [HFW-1:0] h_full;
    logic [SFW-1:0] s_full;
    logic [CW-1:0]  h_val, s_val;

    always_comb begin
        mod_term = RW'(sec_mod(s3_sec)) << RB;
        raw      = s3_neg ? mod_term - RW'(s3_hp) : mod_term + RW'(s3_hp);
        h_prod   = HW'(raw) * HW'(K) + HW'(HALF);
        h_full   = HFW'(h_prod >> RB);
        s_prod   = SW'(s3_sp) * SW'(MAXC) + SW'(HALF);
        s_full   = SFW'(s_prod >> RB);
        h_val    = (s3_dz || h_full >= HMAX_L) ? '0 : h_full[CW-1:0];
        s_val    = (s3_cmax == '0) ? '0
                 : (s_full > MAXC_L) ? MAXC_L[CW-1:0] : s_full[CW-1:0];
    end

    logic       s4_v;
    hsv_pixel_t s4_q;

    always_ff @(posedge clk or negedge reset_int) begin
        if (!reset_int) begin
            s4_v <= 1'b0;
            s4_q <= '0;
        end else if (en) begin
            s4_v      <= s3_v;
            s4_q.data <= PIX_W'({h_val, s_val, s3_cmax});
            s4_q.sop  <= s3_sop;
            s4_q.eop  <= s3_eop;
        end
    end

`ifdef RGB2HSV_SKID_EN
    hsv_pixel_t main_q, skid_q;
    logic       main_v, skid_v, skid_v_nxt, rdy_q, push;

    // pipeline only stalls while the second entry is occupied
    assign en       = ~skid_v;
    assign push     = en & s4_v;
    assign in_ready = rdy_q;

    always_comb begin
        skid_v_nxt = skid_v;
        if (out_ready | ~main_v) skid_v_nxt = 1'b0;
        else if (push)           skid_v_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_int) begin
        if (!reset_int) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            skid_v <= skid_v_nxt;
            rdy_q  <= ~skid_v_nxt;
            if (out_ready | ~main_v) begin
                if (skid_v) begin
                    main_q <= skid_q;
                    main_v <= 1'b1;
                end else begin
                    main_v <= push;
                    if (push) main_q <= s4_q;
                end
            end else if (push) begin
                skid_q <= s4_q;
            end
        end
    end

    assign out_valid = main_v;
    assign out_hsv   = (3*CW)'(main_q.data);
    assign out_sop   = main_q.sop;
    assign out_eop   = main_q.eop;
`else
    assign en = ~s4_v | out_ready;
    // held low until the internal reset releases so no pixel is lost
    assign in_ready  = en & reset_int;
    assign out_valid = s4_v;
    assign out_hsv   = (3*CW)'(s4_q.data);
    assign out_sop   = s4_q.sop;
    assign out_eop   = s4_q.eop;
`endif

endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// Scoreboard bench for rgb_to_hsv_stream: directed vectors, backpressure
// stream, ready-path toggle and mid-stream reset.
module tb_rgb_to_hsv_stream;
    import rgb_to_hsv_pkg::*;

`ifdef RGB2HSV_SKID_EN
    localparam int HMAX = 240;
    localparam int LAT  = 5;
`else
    localparam int HMAX = 180;
    localparam int LAT  = 4;
`endif

    logic        clk, reset;
    logic        in_valid, in_ready, in_sop, in_eop;
    logic [23:0] in_rgb;
    logic        out_valid, out_ready, out_sop, out_eop;
    logic [23:0] out_hsv;

    rgb_to_hsv_stream #(.CW(8), .RB(16), .HUE_MAX(HMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hsv   (out_hsv),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    typedef struct {
        logic [23:0] hsv;
        logic        sop;
        logic        eop;
        int          acc;
        bit          chk;
    } exp_t;

    typedef struct {
        logic [7:0] r, g, b;
        int         h180, h240, s, v;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   bp_on = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: timeout, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic logic [23:0] model(input int r, input int g, input int b);
        int mx, mn, d, base, md;
        longint raw, hh, ss;
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;
        mn = (mn < b) ? mn : b;
        d  = mx - mn;
        if (r >= g && r >= b) begin
            base = g - b;
            md   = (g >= b) ? 0 : 6;
        end else if (g >= b) begin
            base = b - r;
            md   = 2;
        end else begin
            base = r - g;
            md   = 4;
        end
        raw = (longint'(md) << 16) + longint'(base) * longint'(recip_f(16, d));
        hh  = (raw * (HMAX / 6) + 32768) >>> 16;
        if (hh >= HMAX || d == 0) hh = 0;
        ss  = (longint'(d) * longint'(recip_f(16, mx)) * 255 + 32768) >>> 16;
        if (ss > 255) ss = 255;
        if (mx == 0) ss = 0;
        return {hh[7:0], ss[7:0], mx[7:0]};
    endfunction

    task automatic send(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic sop, input logic eop,
                        input logic [23:0] hsv, input bit chk);
        exp_t e;
        int   n;
        n = 0;
        in_rgb   = {r, g, b};
        in_sop   = sop;
        in_eop   = eop;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept: in_ready got 0 want 1");
        end else begin
            e.hsv = hsv;
            e.sop = sop;
            e.eop = eop;
            e.acc = cyc;
            e.chk = chk;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", {31'd0, out_valid}, 1);
    endtask

    // monitor: pops on every transfer, checks hold while stalled
    initial begin
        exp_t        e;
        bit          hold_p;
        logic [25:0] hold_d;
        hold_p = 0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_p = 0;
            end else begin
                if (hold_p)
                    check("hold", {out_valid, out_hsv, out_sop, out_eop},
                          {1'b1, hold_d});
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL stale: got %0h want none", out_hsv);
                    end else begin
                        e = q.pop_front();
                        check("out", {out_hsv, out_sop, out_eop},
                              {e.hsv, e.sop, e.eop});
                        if (e.chk) check("latency", cyc - e.acc, LAT);
                    end
                end
                hold_p = out_valid && !out_ready;
                hold_d = {out_hsv, out_sop, out_eop};
            end
        end
    end

    vec_t vecs[8] = '{
        '{8'd255, 8'd0,   8'd0,   0,   0,   255, 255},
        '{8'd0,   8'd255, 8'd0,   60,  80,  255, 255},
        '{8'd0,   8'd0,   8'd255, 120, 160, 255, 255},
        '{8'd255, 8'd255, 8'd0,   30,  40,  255, 255},
        '{8'd255, 8'd0,   8'd255, 150, 200, 255, 255},
        '{8'd255, 8'd0,   8'd1,   0,   0,   255, 255},
        '{8'd128, 8'd128, 8'd128, 0,   0,   0,   128},
        '{8'd0,   8'd0,   8'd0,   0,   0,   0,   0}
    };

    initial begin
        logic [7:0]  hh;
        logic [23:0] m;
        logic        r0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_rgb    = '0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {out_valid, out_sop, out_eop, out_hsv}, 0);
`ifdef RGB2HSV_SKID_EN
        check("rst_rdy_held", {31'd0, in_ready}, 0);
`endif
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_rdy", {31'd0, in_ready}, 1);

        // directed vectors, no stalls
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hh = (HMAX == 240) ? 8'(vecs[i].h240) : 8'(vecs[i].h180);
            send(vecs[i].r, vecs[i].g, vecs[i].b, i == 0, i == 7,
                 {hh, 8'(vecs[i].s), 8'(vecs[i].v)}, 1);
        end
        drain();

        // 16-pixel packet under random backpressure
        bp_on = 1;
        fork
            begin
                while (bp_on) begin
                    @(posedge clk);
                    #1;
                    if (bp_on) out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    m = model((i * 37 + 11) % 256, (i * 91 + 200) % 256,
                              (i * 53 + 7) % 256);
                    send(8'((i * 37 + 11) % 256), 8'((i * 91 + 200) % 256),
                         8'((i * 53 + 7) % 256), i == 0, i == 15, m, 0);
                end
                bp_on = 0;
            end
        join
        out_ready = 1'b1;
        drain();

        // in_ready versus out_ready with a stalled output
        out_ready = 1'b0;
        send(8'd10, 8'd200, 8'd30, 1'b0, 1'b0, model(10, 200, 30), 0);
        wait_valid();
        #1;
`ifdef RGB2HSV_SKID_EN
        r0 = in_ready;
        check("skid_rdy", {31'd0, r0}, 1);
        out_ready = 1'b1;
        #1;
        check("rdy_indep_hi", {31'd0, in_ready}, {31'd0, r0});
        out_ready = 1'b0;
        #1;
        check("rdy_indep_lo", {31'd0, in_ready}, {31'd0, r0});
`else
        r0 = in_ready;
        check("rdy_stall", {31'd0, r0}, 0);
        out_ready = 1'b1;
        #1;
        check("rdy_follow_hi", {31'd0, in_ready}, 1);
        out_ready = 1'b0;
        #1;
        check("rdy_follow_lo", {31'd0, in_ready}, 0);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // reset with three pixels in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(8'(50 + i), 8'd20, 8'd90, 1'b0, 1'b0, 24'h0, 0);
        wait_valid();
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid", {out_valid, out_sop, out_eop, out_hsv}, 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        hh = (HMAX == 240) ? 8'd80 : 8'd60;
        send(8'd0, 8'd255, 8'd0, 1'b1, 1'b1, {hh, 8'd255, 8'd255}, 1);
        drain();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
